// File: rtl/integ_operator_multi.sv
// Multi-channel saturating/wrapping running-sum integrator. Each en strobe adds the
// latched input vector into per-channel accumulators, one channel per cycle.
module integ_operator_multi #(
  parameter int N   = 5,
  parameter int W   = 16,
  parameter int SAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] in  [N-1:0],
  output logic signed [W-1:0] out [N-1:0],
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [IW-1:0]       idx_reg;
  logic signed [W-1:0] inq_reg [N-1:0];
  logic signed [W-1:0] acc_reg [N-1:0];
  logic signed [W-1:0] out_reg [N-1:0];
  logic                valid_reg;
  logic                overrun_reg;

  logic signed [W:0]   sum_wide;
  logic signed [W-1:0] sum_next;

  // One shared adder; the extra top bit exposes overflow for saturation.
  always_comb begin
    sum_wide = {acc_reg[idx_reg][W-1], acc_reg[idx_reg]} +
               {inq_reg[idx_reg][W-1], inq_reg[idx_reg]};
    sum_next = sum_wide[W-1:0];
    if (SAT != 0 && (sum_wide[W] != sum_wide[W-1])) begin
      sum_next = sum_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc_reg[k] <= '0;
        out_reg[k] <= '0;
        inq_reg[k] <= '0;
      end
    end else if (clr) begin
      // A clear aborts any pass and swallows a coincident strobe.
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc_reg[k] <= '0;
        out_reg[k] <= '0;
      end
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            for (int k = 0; k < N; k++) inq_reg[k] <= in[k];
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (en) overrun_reg <= 1'b1;
          acc_reg[idx_reg] <= sum_next;
          if (idx_reg == IW'(N - 1)) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DONE: begin
          if (en) overrun_reg <= 1'b1;
          for (int k = 0; k < N; k++) out_reg[k] <= acc_reg[k];
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign out[gi] = out_reg[gi];
    end
  endgenerate

  assign valid   = valid_reg;
  assign busy    = (state_reg != IDLE);
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_integ_operator_multi.sv
// Randomized self-checking bench for integ_operator_multi; runs a saturating and a
// wrapping instance side by side against a running-sum reference model.
module tb_integ_operator_multi;

  localparam int N = 5;
  localparam int W = 16;

  typedef logic signed [W-1:0] vec_t [N-1:0];

  logic clk = 1'b0;
  logic reset, en, clr;
  vec_t din, dout_s, dout_w;
  logic valid_s, busy_s, ovr_s, valid_w, busy_w, ovr_w;

  vec_t model_s, model_w;
  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  integ_operator_multi #(.N(N), .W(W), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .in(din),
    .out(dout_s), .valid(valid_s), .busy(busy_s), .overrun(ovr_s)
  );

  integ_operator_multi #(.N(N), .W(W), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .in(din),
    .out(dout_w), .valid(valid_w), .busy(busy_w), .overrun(ovr_w)
  );

  function automatic logic [N*W-1:0] pack(input vec_t a);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = a[k];
    return r;
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3, input int a4);
    vec_t r;
    r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3); r[4] = W'(a4);
    return r;
  endfunction

  // Reference: running sums in plain integer arithmetic, clamped or taken modulo 2^W.
  task automatic model_add(input vec_t v);
    int s;
    for (int k = 0; k < N; k++) begin
      s = int'(model_s[k]) + int'(v[k]);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      model_s[k] = s[W-1:0];
      model_w[k] = model_w[k] + v[k];
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      model_s[k] = '0;
      model_w[k] = '0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
  endtask

  // Issue one strobe and wait (bounded) for valid; lat counts sampled cycles after the en edge.
  task automatic run_pass(input vec_t v, output int lat, output int bcnt);
    @(negedge clk); din = v; en = 1'b1;
    model_add(v);
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < N; k++) din[k] = W'($urandom);
    lat = -1;
    bcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (valid_s) begin
        lat = c;
        break;
      end
      if (busy_s) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    din = mk(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (pack(dout_s) !== '0 || pack(dout_w) !== '0) begin
      errors++; $display("FAIL reset_out: got %h / %h want 0", pack(dout_s), pack(dout_w));
    end
    checks++;
    if ({valid_s, busy_s, ovr_s, valid_w, busy_w, ovr_w} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {valid_s, busy_s, ovr_s, valid_w, busy_w, ovr_w});
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_pass(mk(1, 4, 7, -5, -3), lat, bcnt);
    checks++;
    if (lat !== N + 2) begin errors++; $display("FAIL basic1_latency: got %0d want %0d", lat, N + 2); end
    checks++;
    if (bcnt !== N + 1) begin errors++; $display("FAIL basic1_busy: got %0d want %0d", bcnt, N + 1); end
    checks++;
    if (pack(dout_s) !== pack(mk(1, 4, 7, -5, -3))) begin
      errors++; $display("FAIL basic1_out: got %h want %h", pack(dout_s), pack(mk(1, 4, 7, -5, -3)));
    end
    @(negedge clk);
    checks++;
    if (valid_s !== 1'b0) begin errors++; $display("FAIL basic1_valid_pulse: got %b want 0", valid_s); end
    run_pass(mk(0, 2, 4, 6, 5), lat, bcnt);
    checks++;
    if (bcnt !== N + 1) begin errors++; $display("FAIL basic2_busy: got %0d want %0d", bcnt, N + 1); end
    checks++;
    if (pack(dout_s) !== pack(mk(1, 6, 11, 1, 2)) || pack(dout_w) !== pack(mk(1, 6, 11, 1, 2))) begin
      errors++; $display("FAIL basic2_out: got %h / %h want %h", pack(dout_s), pack(dout_w),
                         pack(mk(1, 6, 11, 1, 2)));
    end
  endtask

  task automatic test_saturate();
    int lat, bcnt;
    do_clr();
    run_pass(mk(32767, -32768, 0, 0, 0), lat, bcnt);
    run_pass(mk(32767, -32768, 0, 0, 0), lat, bcnt);
    checks++;
    if (pack(dout_s) !== pack(mk(32767, -32768, 0, 0, 0))) begin
      errors++; $display("FAIL sat_clamp: got %h want %h", pack(dout_s), pack(mk(32767, -32768, 0, 0, 0)));
    end
    checks++;
    if (pack(dout_w) !== pack(mk(-2, 0, 0, 0, 0))) begin
      errors++; $display("FAIL wrap_double: got %h want %h", pack(dout_w), pack(mk(-2, 0, 0, 0, 0)));
    end
    do_clr();
    run_pass(mk(32767, 0, -32768, 0, 0), lat, bcnt);
    run_pass(mk(1, 0, -1, 0, 0), lat, bcnt);
    checks++;
    if (dout_s[0] !== 16'sh7FFF || dout_w[0] !== 16'sh8000) begin
      errors++; $display("FAIL sat_plus_one: got %h / %h want 7fff / 8000", dout_s[0], dout_w[0]);
    end
    checks++;
    if (dout_s[2] !== 16'sh8000 || dout_w[2] !== 16'sh7FFF) begin
      errors++; $display("FAIL sat_minus_one: got %h / %h want 8000 / 7fff", dout_s[2], dout_w[2]);
    end
  endtask

  task automatic test_overrun();
    int nv;
    vec_t v1;
    do_clr();
    v1 = mk(3, -2, 100, 7, 9);
    @(negedge clk); din = v1; en = 1'b1;
    model_add(v1);
    @(negedge clk); en = 1'b0;
    @(negedge clk); din = mk(50, 50, 50, 50, 50); en = 1'b1;
    @(negedge clk); en = 1'b0;
    nv = 0;
    repeat (12) begin @(negedge clk); if (valid_s) nv++; end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL overrun_valid_count: got %0d want 1", nv); end
    checks++;
    if (pack(dout_s) !== pack(model_s)) begin
      errors++; $display("FAIL overrun_out: got %h want %h", pack(dout_s), pack(model_s));
    end
    checks++;
    if (ovr_s !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", ovr_s); end
    do_clr();
    checks++;
    if (ovr_s !== 1'b0 || pack(dout_s) !== '0) begin
      errors++; $display("FAIL overrun_clr: got ovr=%b out=%h want 0", ovr_s, pack(dout_s));
    end
    // en held high for three edges: one pass, later edges flagged
    v1 = mk(-8, 8, 1, 2, 3);
    @(negedge clk); din = v1; en = 1'b1;
    model_add(v1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    nv = 0;
    repeat (10) begin @(negedge clk); if (valid_s) nv++; end
    checks++;
    if (nv !== 1 || pack(dout_s) !== pack(model_s) || ovr_s !== 1'b1) begin
      errors++; $display("FAIL en_held: got nv=%0d out=%h ovr=%b want nv=1 out=%h ovr=1",
                         nv, pack(dout_s), ovr_s, pack(model_s));
    end
  endtask

  task automatic test_clr_abort();
    int nv, lat, bcnt;
    run_pass(mk(5, 5, 5, 5, 5), lat, bcnt);
    @(negedge clk); din = mk(9, 9, 9, 9, 9); en = 1'b1;
    @(negedge clk); en = 1'b0;
    @(negedge clk); clr = 1'b1; en = 1'b1;
    @(negedge clk); clr = 1'b0; en = 1'b0;
    model_clear();
    nv = 0;
    repeat (10) begin if (valid_s) nv++; @(negedge clk); end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL clr_no_valid: got %0d valids want 0", nv); end
    checks++;
    if (pack(dout_s) !== '0 || ovr_s !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL clr_abort_state: got out=%h ovr=%b busy=%b want 0", pack(dout_s), ovr_s, busy_s);
    end
    // clr together with en from IDLE: no pass starts
    @(negedge clk); clr = 1'b1; en = 1'b1;
    @(negedge clk); clr = 1'b0; en = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || ovr_s !== 1'b0) begin
      errors++; $display("FAIL clr_with_en: got busy=%b ovr=%b want 0 0", busy_s, ovr_s);
    end
    run_pass(mk(1, 1, 1, 1, 1), lat, bcnt);
    checks++;
    if (pack(dout_s) !== pack(mk(1, 1, 1, 1, 1))) begin
      errors++; $display("FAIL clr_then_ones: got %h want %h", pack(dout_s), pack(mk(1, 1, 1, 1, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    run_pass(mk(10, 20, 30, 40, 50), lat, bcnt);
    @(negedge clk); din = mk(1, 2, 3, 4, 5); en = 1'b1;
    @(negedge clk); en = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_clear();
    checks++;
    if (pack(dout_s) !== '0 || {valid_s, busy_s, ovr_s} !== 3'b0) begin
      errors++; $display("FAIL reset_mid: got out=%h flags=%b want 0", pack(dout_s), {valid_s, busy_s, ovr_s});
    end
    run_pass(mk(-7, 6, -5, 4, -3), lat, bcnt);
    checks++;
    if (lat !== N + 2 || pack(dout_s) !== pack(mk(-7, 6, -5, 4, -3))) begin
      errors++; $display("FAIL reset_mid_after: got lat=%0d out=%h want %0d %h",
                         lat, pack(dout_s), N + 2, pack(mk(-7, 6, -5, 4, -3)));
    end
  endtask

  // Random vectors, back-to-back strobes at minimum spacing, both arithmetic modes.
  task automatic test_random();
    int lat, bcnt;
    vec_t v;
    do_clr();
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < N; k++)
        v[k] = ($urandom_range(0, 2) == 0) ? W'($urandom) : W'($urandom_range(0, 2000) - 1000);
      run_pass(v, lat, bcnt);
      checks++;
      if (lat !== N + 2 || pack(dout_s) !== pack(model_s) || pack(dout_w) !== pack(model_w)) begin
        errors++; $display("FAIL random_%0d: got lat=%0d sat=%h wrap=%h want %0d sat=%h wrap=%h",
                           t, lat, pack(dout_s), pack(dout_w), N + 2, pack(model_s), pack(model_w));
      end
    end
    checks++;
    if (ovr_s !== 1'b0 || ovr_w !== 1'b0) begin
      errors++; $display("FAIL back_to_back_overrun: got %b %b want 0 0", ovr_s, ovr_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_overrun();
    test_clr_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
